// File: rtl/logical_operand_sequencer.sv
// rtl/logical_operand_sequencer.sv - byte-stream operand sequencer for the 8-bit logical unit (optional LOGSEQ_TXN_COUNT_EN)
module logical_operand_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 op_o,
  input  logic [WIDTH-1:0]     y_i,
  output logic [WIDTH-1:0]     res_data_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
`ifdef LOGSEQ_TXN_COUNT_EN
  output logic [CNT_WIDTH-1:0] txn_count_o,
`endif
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             in_xfer;
  logic             res_xfer;

  // Only bit 0 of the op byte selects the operation; the rest is dropped.
  logic unused_op_bits;
  assign unused_op_bits = ^in_data_i[WIDTH-1:1];

  // Input is accepted only in the three operand-gathering states and never in reset.
  assign in_ready_o = rst_ni && ((state_q == S_A) || (state_q == S_B) || (state_q == S_OP));
  assign in_xfer    = in_valid_i && in_ready_o;
  assign res_xfer   = res_valid_q && res_ready_i;

  // Sequencer FSM: gathers A, B, OP, samples the logical unit, then holds the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (in_xfer) begin
            a_q     <= in_data_i;
            state_q <= S_B;
            busy_q  <= 1'b1;
          end
        end
        S_B: begin
          if (in_xfer) begin
            b_q     <= in_data_i;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (in_xfer) begin
            op_q    <= in_data_i[0];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Operands have been stable for a full cycle, so Y is settled here.
          res_data_q  <= y_i;
          res_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (res_xfer) begin
            res_valid_q <= 1'b0;
            state_q     <= S_A;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_A;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGSEQ_TXN_COUNT_EN
  logic [CNT_WIDTH-1:0] txn_count_q;
  logic [CNT_WIDTH-1:0] txn_count_d;

  // Next count wraps naturally at the counter width.
  assign txn_count_d = txn_count_q + 1'b1;

  // Count completed result transfers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txn_count_q <= '0;
    end else if (res_xfer) begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count_o = txn_count_q;
`else
  localparam int UnusedCntWidth = CNT_WIDTH;
`endif

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign op_o        = op_q;
  assign res_data_o  = res_data_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_logical_operand_sequencer.sv
// tb/tb_logical_operand_sequencer.sv - self-checking bench for logical_operand_sequencer
module tb_logical_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       op_out;
  logic [7:0] y;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
`ifdef LOGSEQ_TXN_COUNT_EN
  logic [7:0] txn_count;
`endif

  int checks   = 0;
  int failures = 0;
  int txn_done = 0;

  logical_operand_sequencer #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_o         (a_out),
    .b_o         (b_out),
    .op_o        (op_out),
    .y_i         (y),
    .res_data_o  (res_data),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
`ifdef LOGSEQ_TXN_COUNT_EN
    .txn_count_o (txn_count),
`endif
    .busy_o      (busy)
  );

  // The logical unit itself: AND when op=1, OR when op=0.
  assign y = op_out ? (a_out & b_out) : (a_out | b_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one byte after 'idle' empty cycles; busy_exp is the BUSY level during the gap.
  task automatic send_byte(input logic [7:0] d, input int idle, input logic busy_exp);
    logic took;
    took = 1'b0;
    for (int i = 0; i < idle; i++) begin
      in_valid = 1'b0;
      tick();
      chk("busy_idle", busy, busy_exp);
      chk("ready_idle", in_ready, 1'b1);
    end
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      took = in_ready;
      tick();
      if (took) break;
    end
    if (!took) chk("in_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // One full transaction; hold = cycles the result is back-pressured.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input int hold);
    logic [7:0] exp_y;
    exp_y = op[0] ? (a & b) : (a | b);
    send_byte(a, gap, 1'b0);
    send_byte(b, gap, 1'b1);
    send_byte(op, gap, 1'b1);
    // After the OP edge: operands visible, result not yet valid.
    chk("exec_valid", res_valid, 1'b0);
    chk("exec_ready", in_ready, 1'b0);
    chk("exec_a", a_out, a);
    chk("exec_b", b_out, b);
    chk("exec_op", op_out, op[0]);
    res_ready = (hold == 0);
    tick();
    chk("out_valid", res_valid, 1'b1);
    chk("out_data", res_data, exp_y);
    chk("out_busy", busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_data", res_data, exp_y);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_a", a_out, a);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    txn_done++;
    res_ready = 1'b0;
    chk("drain_valid", res_valid, 1'b0);
    chk("drain_busy", busy, 1'b0);
    chk("drain_ready", in_ready, 1'b1);
    chk("keep_a", a_out, a);
    chk("keep_op", op_out, op[0]);
`ifdef LOGSEQ_TXN_COUNT_EN
    chk("txn_count", txn_count, txn_done % 256);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    #2;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_outs", {a_out, b_out, res_data, 7'd0, op_out}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
    tick();

    // Directed cases.
    run_txn(8'hF0, 8'h3C, 8'h01, 0, 0);
    run_txn(8'hF0, 8'h3C, 8'hFE, 0, 0);
    run_txn(8'h12, 8'h34, 8'h01, 0, 10);
    run_txn(8'h55, 8'h0F, 8'h01, 3, 0);

    // RES_READY with no pending result has no effect.
    res_ready = 1'b1;
    tick();
    chk("idle_rr_valid", res_valid, 1'b0);
    chk("idle_rr_ready", in_ready, 1'b1);
    res_ready = 1'b0;

    // Asynchronous reset after A and B are loaded.
    send_byte(8'hC3, 0, 1'b0);
    send_byte(8'h3C, 0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_outs", {a_out, b_out, res_data, 6'd0, res_valid, op_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    txn_done = 0;
    run_txn(8'h81, 8'h18, 8'h00, 0, 0);

    // Randomised transactions against the reference expression.
    for (int t = 0; t < 30; t++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

`ifdef LOGSEQ_TXN_COUNT_EN
    // Walk the counter through its wrap point.
    while (txn_done % 256 != 250) run_txn(8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    for (int t = 0; t < 8; t++) run_txn(8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
